// File: rtl/ahb_response_mux.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_response_mux
//  Description : Return path of one master port of a multilayer AHB
//                interconnect. Registers the decoder select at the address
//                phase, muxes the selected slave's HRDATA/HREADYOUT/HRESP
//                back to the master, and hosts the default slave that
//                answers unmapped accesses with a two-cycle ERROR response.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_response_mux #(
    parameter int NUM_SLAVES = 2,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                             i_hclk,
    input  logic                             i_hreset,
    input  logic [NUM_SLAVES-1:0]            i_hsel,
    input  logic [1:0]                       i_htrans,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_hrdata,
    input  logic [NUM_SLAVES-1:0]            i_hreadyout,
    input  logic [NUM_SLAVES-1:0]            i_hresp,
    output logic [DATA_WIDTH-1:0]            o_hrdata,
    output logic                             o_hready,
    output logic                             o_hresp,
    output logic [NUM_SLAVES-1:0]            o_dp_sel,
    output logic [CNT_WIDTH-1:0]             o_err_count
);

    // Default-slave states
    localparam logic [1:0] c_DS_IDLE = 2'd0;
    localparam logic [1:0] c_DS_ERR1 = 2'd1;
    localparam logic [1:0] c_DS_ERR2 = 2'd2;

    logic [NUM_SLAVES-1:0] r_dp_sel_q;
    logic [NUM_SLAVES-1:0] w_dp_sel_d;
    logic [1:0]            r_state_q;
    logic [1:0]            w_state_d;
    logic [CNT_WIDTH-1:0]  r_err_count_q;
    logic [CNT_WIDTH-1:0]  w_err_count_d;

    logic [NUM_SLAVES-1:0] w_hsel_lowest;
    logic [DATA_WIDTH-1:0] w_hrdata;
    logic                  w_hready;
    logic                  w_hresp;

    // HTRANS[0] only distinguishes IDLE/BUSY and NONSEQ/SEQ, which are
    // treated identically here.
    logic w_unused;
    assign w_unused = i_htrans[0];

    // Priority-pick the lowest asserted select so overlapping decoder
    // ranges resolve to the lowest slave index.
    always_comb begin
        w_hsel_lowest = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (i_hsel[k]) begin
                w_hsel_lowest    = '0;
                w_hsel_lowest[k] = 1'b1;
            end
        end
    end

    // Response mux: selected slave, or the default-slave/idle response.
    always_comb begin
        w_hrdata = '0;
        w_hready = 1'b1;
        w_hresp  = 1'b0;
        if (r_dp_sel_q != '0) begin
            // One-hot select, so an AND-OR mux is exact.
            w_hready = 1'b0;
            for (int k = 0; k < NUM_SLAVES; k++) begin
                if (r_dp_sel_q[k]) begin
                    w_hrdata = w_hrdata | i_hrdata[k*DATA_WIDTH +: DATA_WIDTH];
                    w_hready = w_hready | i_hreadyout[k];
                    w_hresp  = w_hresp  | i_hresp[k];
                end
            end
        end else begin
            case (r_state_q)
                c_DS_ERR1: begin
                    w_hready = 1'b0;
                    w_hresp  = 1'b1;
                end
                c_DS_ERR2: begin
                    w_hready = 1'b1;
                    w_hresp  = 1'b1;
                end
                default: begin
                    w_hready = 1'b1;
                    w_hresp  = 1'b0;
                end
            endcase
        end
    end

    // Next-state: sample the address phase only when the bus is ready;
    // ERR1 always advances to ERR2 since it is never a sample cycle.
    always_comb begin
        w_dp_sel_d    = r_dp_sel_q;
        w_state_d     = r_state_q;
        w_err_count_d = r_err_count_q;
        if (w_hready) begin
            if (i_htrans[1]) begin
                if (i_hsel != '0) begin
                    w_dp_sel_d = w_hsel_lowest;
                    w_state_d  = c_DS_IDLE;
                end else begin
                    w_dp_sel_d = '0;
                    w_state_d  = c_DS_ERR1;
                    if (r_err_count_q != {CNT_WIDTH{1'b1}}) begin
                        w_err_count_d = r_err_count_q + CNT_WIDTH'(1);
                    end
                end
            end else begin
                w_dp_sel_d = '0;
                w_state_d  = c_DS_IDLE;
            end
        end else if (r_state_q == c_DS_ERR1) begin
            w_state_d = c_DS_ERR2;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_dp_sel_q    <= '0;
            r_state_q     <= c_DS_IDLE;
            r_err_count_q <= '0;
        end else begin
            r_dp_sel_q    <= w_dp_sel_d;
            r_state_q     <= w_state_d;
            r_err_count_q <= w_err_count_d;
        end
    end

    assign o_hrdata    = w_hrdata;
    assign o_hready    = w_hready;
    assign o_hresp     = w_hresp;
    assign o_dp_sel    = r_dp_sel_q;
    assign o_err_count = r_err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_response_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_response_mux
//  Description : Self-checking bench for ahb_response_mux. A driver issues
//                one bus cycle at a time and pushes the expected response
//                from a transaction-level model; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_response_mux;

    localparam int NS = 2;
    localparam int DW = 32;
    localparam int CW = 8;

    logic           clk = 1'b0;
    logic           hreset;
    logic [NS-1:0]  hsel;
    logic [1:0]     htrans;
    logic [NS*DW-1:0] hrdata;
    logic [NS-1:0]  hreadyout;
    logic [NS-1:0]  hresp_in;
    logic [DW-1:0]  o_hrdata;
    logic           o_hready;
    logic           o_hresp;
    logic [NS-1:0]  o_dp_sel;
    logic [CW-1:0]  o_err_count;

    ahb_response_mux #(
        .NUM_SLAVES (NS),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_hclk      (clk),
        .i_hreset    (hreset),
        .i_hsel      (hsel),
        .i_htrans    (htrans),
        .i_hrdata    (hrdata),
        .i_hreadyout (hreadyout),
        .i_hresp     (hresp_in),
        .o_hrdata    (o_hrdata),
        .o_hready    (o_hready),
        .o_hresp     (o_hresp),
        .o_dp_sel    (o_dp_sel),
        .o_err_count (o_err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          rdy;
        logic          rsp;
        logic [NS-1:0] sel;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    // Transaction-level model: which slave owns the data phase (-1 none),
    // how many ERROR cycles remain, and the saturating unmapped count.
    int m_sel      = -1;
    int m_err_left = 0;
    int m_cnt      = 0;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;

    // One bus cycle: drive inputs, predict this cycle's response, then
    // advance the model at the rising edge.
    task automatic cyc(input string nm, input bit rst, input logic [NS-1:0] sel,
                       input logic [1:0] tr, input logic [NS*DW-1:0] rd,
                       input logic [NS-1:0] ry, input logic [NS-1:0] rs);
        exp_t e;
        @(negedge clk);
        hreset    = rst;
        hsel      = sel;
        htrans    = tr;
        hrdata    = rd;
        hreadyout = ry;
        hresp_in  = rs;
        e     = '0;
        e.cnt = CW'(m_cnt);
        if (m_sel >= 0) begin
            e.d   = rd[m_sel*DW +: DW];
            e.rdy = ry[m_sel];
            e.rsp = rs[m_sel];
            e.sel = NS'(1 << m_sel);
        end else begin
            e.rdy = (m_err_left != 2);
            e.rsp = (m_err_left > 0);
        end
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        if (rst) begin
            m_sel = -1; m_err_left = 0; m_cnt = 0;
        end else if (e.rdy) begin
            if (tr >= 2) begin
                if (sel != 0) begin
                    m_err_left = 0;
                    for (int k = NS - 1; k >= 0; k--) if (sel[k]) m_sel = k;
                end else begin
                    m_sel = -1; m_err_left = 2;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                end
            end else begin
                m_sel = -1; m_err_left = 0;
            end
        end else if (m_err_left == 2) begin
            m_err_left = 1;
        end
    endtask

    // Monitor: compare every presented response against the scoreboard.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_tests++;
                if ({o_hrdata, o_hready, o_hresp, o_dp_sel, o_err_count} !== e) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got data=%h rdy=%b rsp=%b sel=%b cnt=%0d, expected data=%h rdy=%b rsp=%b sel=%b cnt=%0d",
                             nm, $time, o_hrdata, o_hready, o_hresp, o_dp_sel, o_err_count,
                             e.d, e.rdy, e.rsp, e.sel, e.cnt);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        logic [NS*DW-1:0] rd;
        hreset = 1'b1; hsel = '0; htrans = IDLE; hrdata = '0;
        hreadyout = '1; hresp_in = '0;
        @(posedge clk);

        // Reset held for two cycles, then released.
        cyc("reset0", 1, 2'b00, IDLE, '0, 2'b11, 2'b00);
        cyc("reset1", 1, 2'b00, IDLE, '0, 2'b11, 2'b00);

        // Mapped read from slave 1.
        rd = {32'hDEADBEEF, 32'h12345678};
        cyc("map_addr", 0, 2'b10, NONSEQ, rd, 2'b11, 2'b00);
        cyc("map_data", 0, 2'b00, IDLE,   rd, 2'b11, 2'b00);

        // Slave 0 inserts three wait states while i_hsel wanders.
        rd = {32'hAAAA5555, 32'hCAFEF00D};
        cyc("wait_addr", 0, 2'b01, NONSEQ, rd, 2'b11, 2'b00);
        cyc("wait1",     0, 2'b10, NONSEQ, rd, 2'b10, 2'b00);
        cyc("wait2",     0, 2'b00, SEQ,    rd, 2'b10, 2'b00);
        cyc("wait3",     0, 2'b11, NONSEQ, rd, 2'b10, 2'b00);
        cyc("wait_done", 0, 2'b00, IDLE,   rd, 2'b11, 2'b00);

        // Unmapped accesses, back-to-back.
        cyc("unm_addr",  0, 2'b00, NONSEQ, rd, 2'b11, 2'b00);
        cyc("unm_err1",  0, 2'b01, NONSEQ, rd, 2'b11, 2'b00);
        cyc("unm_err2",  0, 2'b00, NONSEQ, rd, 2'b11, 2'b00);
        cyc("unm2_err1", 0, 2'b00, IDLE,   rd, 2'b11, 2'b00);
        cyc("unm2_err2", 0, 2'b00, IDLE,   rd, 2'b11, 2'b00);
        cyc("unm_idle",  0, 2'b00, IDLE,   rd, 2'b11, 2'b00);

        // Overlapping select, then IDLE with a select present.
        cyc("ovl_addr",  0, 2'b11, NONSEQ, rd, 2'b11, 2'b00);
        cyc("idle_sel",  0, 2'b10, IDLE,   rd, 2'b11, 2'b01);
        cyc("idle_resp", 0, 2'b00, IDLE,   rd, 2'b11, 2'b11);

        // Counter saturation: 300 unmapped accesses.
        for (int i = 0; i < 600; i++) begin
            cyc("sat", 0, 2'b00, NONSEQ, rd, 2'b11, 2'b00);
        end
        cyc("sat_end", 0, 2'b00, IDLE, rd, 2'b11, 2'b00);

        // Reset asserted while in ERR1.
        cyc("rst_addr", 0, 2'b00, NONSEQ, rd, 2'b11, 2'b00);
        cyc("rst_err1", 1, 2'b00, IDLE,   rd, 2'b11, 2'b00);
        cyc("rst_after", 0, 2'b00, IDLE,  rd, 2'b11, 2'b00);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            cyc("rand", ($urandom % 64) == 0, NS'($urandom), 2'($urandom),
                {$urandom, $urandom},
                {($urandom % 4) != 0, ($urandom % 4) != 0},
                NS'($urandom));
        end

        @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d responses unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
